// File: rtl/target_track_table.sv
// Target track table: per-target X/Y/Z/T coordinate store with valid flags,
// saturating age counters, staleness flagging and a registered write-first read port.
module target_track_table #(
    parameter int NUM_TARGETS = 16,
    parameter int COORD_W     = 8,
    parameter int SEL_W       = $clog2(NUM_TARGETS),
    parameter int AGE_W       = 8,
    parameter int STALE_LIMIT = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [SEL_W-1:0]   wr_sel,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [COORD_W-1:0] wr_z,
    input  logic [COORD_W-1:0] wr_t,
    input  logic               clr_en,
    input  logic [SEL_W-1:0]   clr_sel,
    input  logic               rd_en,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic               rd_valid,
    output logic               rd_hit,
    output logic               rd_stale,
    output logic [AGE_W-1:0]   rd_age,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic [COORD_W-1:0] rd_z,
    output logic [COORD_W-1:0] rd_t,
    output logic [SEL_W:0]     num_valid,
    output logic               sel_err
);

    typedef struct packed {
        logic               valid;
        logic [AGE_W-1:0]   age;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
        logic [COORD_W-1:0] t;
    } entry_t;

    entry_t                 ent_q [NUM_TARGETS];
    entry_t                 ent_d [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] wr_hit;
    logic [NUM_TARGETS-1:0] clr_hit;
    logic [NUM_TARGETS-1:0] rd_match;
    entry_t                 rd_ent;
    logic                   rd_stale_d;
    logic [SEL_W:0]         valid_cnt;
    logic                   sel_err_d;

    // Decoding against every legal index means an out-of-range select matches
    // nothing, so the operation is dropped without a separate bounds check.
    always_comb begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
            wr_hit[i]   = wr_en  && (wr_sel  == SEL_W'(i));
            clr_hit[i]  = clr_en && (clr_sel == SEL_W'(i));
            rd_match[i] = rd_en  && (rd_sel  == SEL_W'(i));
        end
    end

    assign sel_err_d = (wr_en  && !(|wr_hit))  ||
                       (clr_en && !(|clr_hit)) ||
                       (rd_en  && !(|rd_match));

    // NOTE: every variable in a combinational block is given a default before
    // any conditional update; a missing default on some path infers a latch.
    always_comb begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
            ent_d[i] = ent_q[i];
            if (wr_hit[i]) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].age   = '0;
                ent_d[i].x     = wr_x;
                ent_d[i].y     = wr_y;
                ent_d[i].z     = wr_z;
                ent_d[i].t     = wr_t;
            end else if (clr_hit[i]) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].age   = '0;
            end else if (ent_q[i].valid && (ent_q[i].age != '1)) begin
                ent_d[i].age = ent_q[i].age + AGE_W'(1);
            end
        end
    end

    // Read data comes from the next-state table, so a same-edge write or
    // clear of the selected entry is already visible (write-first).
    always_comb begin
        rd_ent = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (rd_match[i] && ent_d[i].valid) begin
                rd_ent = ent_d[i];
            end
        end
        rd_stale_d = rd_ent.valid && (rd_ent.age >= AGE_W'(STALE_LIMIT));
    end

    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            valid_cnt = valid_cnt + (SEL_W+1)'(ent_d[i].valid);
        end
    end

    // NOTE: the table array is cleared by reset as well as the flags, because
    // stored coordinates must read back as zero after reset; all state here
    // uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                ent_q[i] <= '0;
            end
            rd_valid  <= 1'b0;
            rd_hit    <= 1'b0;
            rd_stale  <= 1'b0;
            rd_age    <= '0;
            rd_x      <= '0;
            rd_y      <= '0;
            rd_z      <= '0;
            rd_t      <= '0;
            num_valid <= '0;
            sel_err   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                ent_q[i] <= ent_d[i];
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_hit   <= rd_ent.valid;
                rd_stale <= rd_stale_d;
                rd_age   <= rd_ent.age;
                rd_x     <= rd_ent.x;
                rd_y     <= rd_ent.y;
                rd_z     <= rd_ent.z;
                rd_t     <= rd_ent.t;
            end
            num_valid <= valid_cnt;
            sel_err   <= sel_err_d;
        end
    end

endmodule
